// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables (1-based DES bit numbering),
// per-round shift amounts, key-schedule state enum and a generic
// table-driven permute used by both the key schedule and the round function.
package des_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_e;

  // A permutation table holds up to 64 one-based source bit numbers.
  // Entry [n-1] of an n-entry table describes output bit 1 (the MSB).
  typedef logic [63:0][7:0] perm_tbl_t;

  // PC-1: 64-bit key -> 56-bit C||D (parity bits dropped).
  localparam logic [55:0][7:0] PC1_TBL = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  // PC-2: 56-bit C||D -> 48-bit round subkey.
  localparam logic [47:0][7:0] PC2_TBL = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  // Left-rotation amount S(i) for round i, stored at index i-1.
  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Generic DES permutation. src holds src_w valid bits in [src_w-1:0],
  // MSB = DES bit 1. The result holds dst_w bits in [dst_w-1:0], MSB-first.
  // Callers left-pad narrower tables with zero entries to 64 slots.
  function automatic logic [63:0] permute(input logic [63:0] src,
                                          input int         src_w,
                                          input perm_tbl_t  tbl,
                                          input int         dst_w);
    logic [63:0] res;
    logic [5:0]  idx;
    res = '0;
    idx = '0;
    for (int j = 0; j < 64; j++) begin
      if (j < dst_w) begin
        idx    = 6'(src_w - int'(tbl[j]));
        res[j] = src[idx];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: registered 56-bit C||D to the 48-bit round subkey.
// Purely combinational.
module des_pc2 (
  input  logic [55:0] cd,
  output logic [47:0] subkey
);
  import des_pkg::*;

  // Select 48 of the 56 C||D bits in PC-2 order.
  always_comb begin
    subkey = 48'(permute({8'd0, cd}, 56, {128'd0, PC2_TBL}, 48));
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule. PC-1 is applied once when a schedule starts;
// afterwards each accepted subkey rotates the C/D halves toward the next
// round, and PC-2 of the registered C/D state drives the subkey output.
//
// Handshake: the subkey channel is valid/ready. subkey_valid is high for the
// whole ACTIVE state and never drops without a transfer; a transfer happens
// on a rising edge where subkey_valid && subkey_ready, and subkey/round hold
// their values on every edge without a transfer. The start channel uses
// start_ready as its ready: a start is accepted on an edge where
// start && start_ready, and is otherwise ignored (never queued).
//
// The round output is 4 bits wide, so round 16 reads as 4'd0 while
// subkey_valid is high; in IDLE round is 4'd0 with subkey_valid low.
module des_key_schedule #(
  parameter int unsigned CHECK_PARITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        start,
  output logic        start_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        done,
  output logic        parity_err
);
  import des_pkg::*;

  ks_state_e   state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [4:0]  round_q, round_d;
  logic        dir_q, dir_d;
  logic        done_q, done_d;
  logic        parity_err_q, parity_err_d;

  logic [55:0] pc1_key;
  logic        key_parity_bad;
  logic        last_round;

  function automatic logic [27:0] rotl28(input logic [27:0] x,
                                         input logic [1:0]  s);
    case (s)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x,
                                         input logic [1:0]  s);
    case (s)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  // PC-1 of the incoming key and the odd-parity check of its eight bytes.
  always_comb begin
    pc1_key        = 56'(permute(key, 64, {64'd0, PC1_TBL}, 56));
    key_parity_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if ((^key[8*b +: 8]) == 1'b0) key_parity_bad = 1'b1;
    end
  end

  // The last subkey is K16 when encrypting and K1 when decrypting.
  always_comb begin
    last_round = dir_q ? (round_q == 5'd1) : (round_q == 5'd16);
  end

  // Next-state logic for the schedule: start, advance and completion.
  always_comb begin
    state_d      = state_q;
    cd_d         = cd_q;
    round_d      = round_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    parity_err_d = parity_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = ACTIVE;
          dir_d        = decrypt;
          parity_err_d = (CHECK_PARITY != 0) && key_parity_bad;
          if (decrypt) begin
            // C16/D16 equals C0/D0 because the 16 rotations total 28.
            cd_d    = pc1_key;
            round_d = 5'd16;
          end else begin
            cd_d    = {rotl28(pc1_key[55:28], 2'd1), rotl28(pc1_key[27:0], 2'd1)};
            round_d = 5'd1;
          end
        end
      end
      ACTIVE: begin
        if (subkey_ready) begin
          if (last_round) begin
            state_d = IDLE;
            round_d = 5'd0;
            done_d  = 1'b1;
          end else if (dir_q) begin
            // Undo the rotation that produced the current round: S(round).
            round_d = round_q - 5'd1;
            cd_d    = {rotr28(cd_q[55:28], SHIFT_TBL[4'(round_q - 5'd1)]),
                       rotr28(cd_q[27:0],  SHIFT_TBL[4'(round_q - 5'd1)])};
          end else begin
            // Advance to round+1 with S(round+1), stored at index round.
            round_d = round_q + 5'd1;
            cd_d    = {rotl28(cd_q[55:28], SHIFT_TBL[round_q[3:0]]),
                       rotl28(cd_q[27:0],  SHIFT_TBL[round_q[3:0]])};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cd_q         <= '0;
      round_q      <= '0;
      dir_q        <= 1'b0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      round_q      <= round_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

  assign start_ready  = (state_q == IDLE);
  assign subkey_valid = (state_q == ACTIVE);
  assign round        = round_q[3:0];
  assign done         = done_q;
  assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: a parity-checking instance and a default
// instance share all inputs. Subkeys are predicted from the DES tables with
// cumulative rotation counts and compared through an expected queue.
module tb_des_key_schedule;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key;
  logic        decrypt;
  logic        start;
  logic        subkey_ready;

  logic        start_ready_p, subkey_valid_p, done_p, parity_err_p;
  logic [47:0] subkey_p;
  logic [3:0]  round_p;
  logic        start_ready_n, subkey_valid_n, done_n, parity_err_n;
  logic [47:0] subkey_n;
  logic [3:0]  round_n;

  always #5 clk = ~clk;

  des_key_schedule #(.CHECK_PARITY(1)) dut_p (
    .clk(clk), .rst(rst), .key(key), .decrypt(decrypt), .start(start),
    .start_ready(start_ready_p), .subkey(subkey_p), .subkey_valid(subkey_valid_p),
    .subkey_ready(subkey_ready), .round(round_p), .done(done_p),
    .parity_err(parity_err_p)
  );

  des_key_schedule dut_n (
    .clk(clk), .rst(rst), .key(key), .decrypt(decrypt), .start(start),
    .start_ready(start_ready_n), .subkey(subkey_n), .subkey_valid(subkey_valid_n),
    .subkey_ready(subkey_ready), .round(round_n), .done(done_n),
    .parity_err(parity_err_n)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [51:0] exp_q[$];   // {round[3:0], subkey[47:0]}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int pc1_t[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                    60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                    29,21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shift_t[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // K1..K16: Ci/Di are C0/D0 rotated left by the running total of shifts.
  function automatic void model_schedule(input logic [63:0] k, output logic [47:0] ks[16]);
    bit base[56];
    bit cur[56];
    int total;
    for (int i = 0; i < 56; i++) base[i] = k[64 - pc1_t[i]];
    total = 0;
    for (int r = 0; r < 16; r++) begin
      total += shift_t[r];
      for (int j = 0; j < 28; j++) begin
        cur[j]      = base[(j + total) % 28];
        cur[28 + j] = base[28 + (j + total) % 28];
      end
      for (int m = 0; m < 48; m++) ks[r][47 - m] = cur[pc2_t[m] - 1];
    end
  endfunction

  function automatic logic model_parity_bad(input logic [63:0] k);
    for (int b = 0; b < 8; b++) begin
      if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [47:0] exp_first;
    logic [47:0] exp_second;
    logic [47:0] exp_last;
    logic        exp_par;
    int          ready_mode;   // 0: ready always high, 1: random ready and input noise
    int          stall_round;  // hold ready low 5 cycles at this round (0 = none)
    int          start_round;  // pulse start at this round (0 = none)
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk_model(input logic [63:0] k, input logic dec, input int mode,
                                    input int stall_r, input int start_r);
    vec_t v;
    logic [47:0] ks[16];
    model_schedule(k, ks);
    v.key         = k;
    v.dec         = dec;
    v.exp_first   = dec ? ks[15] : ks[0];
    v.exp_second  = dec ? ks[14] : ks[1];
    v.exp_last    = dec ? ks[0]  : ks[15];
    v.exp_par     = model_parity_bad(k);
    v.ready_mode  = mode;
    v.stall_round = stall_r;
    v.start_round = start_r;
    return v;
  endfunction

  // ---------------- driver: one full schedule ----------------
  task automatic run_schedule(input vec_t v);
    logic [47:0] ks[16];
    logic [51:0] e;
    logic [47:0] seen[$];
    logic [47:0] held_sk;
    logic [3:0]  held_rd;
    logic        have_prev;
    bit          stalled, pulsed;
    int          cycles, budget;

    model_schedule(v.key, ks);
    exp_q.delete();
    for (int r = 0; r < 16; r++) begin
      int idx;
      idx = v.dec ? 15 - r : r;
      exp_q.push_back({4'(idx + 1), ks[idx]});
    end

    @(negedge clk);
    check("start_ready_idle", start_ready_p, 1);
    key = v.key; decrypt = v.dec; start = 1'b1; subkey_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("valid_after_start", subkey_valid_p, 1);
    check("start_ready_busy", start_ready_p, 0);
    check("parity_at_start", parity_err_p, v.exp_par);
    check("parity_unchecked", parity_err_n, 0);

    cycles = 1; budget = 0; stalled = 0; pulsed = 0; have_prev = 0;
    held_sk = '0; held_rd = '0;
    while (exp_q.size() > 0 && budget < 400) begin
      budget++;
      if (subkey_valid_p !== 1'b1) begin
        check("valid_held", subkey_valid_p, 1);
        break;
      end
      if (have_prev) begin
        check("stable_subkey", subkey_p, held_sk);
        check("stable_round", round_p, held_rd);
      end
      if (v.stall_round > 0 && !stalled && round_p == 4'(v.stall_round)) begin
        stalled = 1; held_sk = subkey_p; held_rd = round_p; subkey_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          key = {$urandom, $urandom}; decrypt = ~decrypt;
          @(negedge clk); cycles++;
          check("stall_subkey", subkey_p, held_sk);
          check("stall_round", round_p, held_rd);
          check("stall_valid", subkey_valid_p, 1);
        end
      end
      if (v.start_round > 0 && !pulsed && round_p == 4'(v.start_round)) begin
        pulsed = 1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (v.ready_mode == 0) begin
        subkey_ready = 1'b1;
      end else begin
        subkey_ready = ($urandom_range(0, 3) != 0);
        key = {$urandom, $urandom};
        decrypt = 1'($urandom_range(0, 1));
        start = start | ($urandom_range(0, 7) == 0);
      end
      if (subkey_ready) begin
        e = exp_q.pop_front();
        check("subkey", subkey_p, e[47:0]);
        check("round", round_p, e[51:48]);
        check("subkey_default_inst", subkey_n, e[47:0]);
        seen.push_back(subkey_p);
        have_prev = 0;
      end else begin
        have_prev = 1; held_sk = subkey_p; held_rd = round_p;
      end
      @(negedge clk); cycles++;
    end
    if (exp_q.size() > 0) check("schedule_budget", exp_q.size(), 0);
    start = 1'b0; subkey_ready = 1'b0;

    check("done_pulse", done_p, 1);
    check("start_ready_on_done", start_ready_p, 1);
    check("valid_low_on_done", subkey_valid_p, 0);
    check("round_cleared", round_p, 0);
    check("parity_held", parity_err_p, v.exp_par);
    if (v.ready_mode == 0 && v.stall_round == 0) check("done_latency", cycles, 17);
    if (seen.size() == 16) begin
      check("first_subkey", seen[0], v.exp_first);
      check("second_subkey", seen[1], v.exp_second);
      check("last_subkey", seen[15], v.exp_last);
    end else begin
      check("subkey_count", seen.size(), 16);
    end
    @(negedge clk);
    check("done_one_cycle", done_p, 0);
  endtask

  // ---------------- hand sequence: async reset mid-schedule ----------------
  task automatic reset_mid_schedule();
    @(negedge clk);
    key = 64'h133457799BBCDFF1; decrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; subkey_ready = 1'b1;
    for (int c = 0; c < 40 && round_p != 4'd9; c++) @(negedge clk);
    check("reached_round9", round_p, 9);
    #2 rst = 1'b0;
    #1;
    check("rst_valid", subkey_valid_p, 0);
    check("rst_round", round_p, 0);
    check("rst_start_ready", start_ready_p, 1);
    check("rst_subkey", subkey_p, 0);
    check("rst_done", done_p, 0);
    subkey_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- main sequence and final report ----------------
  initial begin
    rst = 1'b0; key = '0; decrypt = 1'b0; start = 1'b0; subkey_ready = 1'b0;

    vecs[0] = mk_model(64'h133457799BBCDFF1, 1'b0, 0, 0, 0);
    vecs[0].exp_first  = 48'h1B02EFFC7072;
    vecs[0].exp_second = 48'h79AED9DBC9E5;
    vecs[0].exp_last   = 48'hCB3D8B0E17F5;
    vecs[0].exp_par    = 1'b0;
    vecs[1] = mk_model(64'h133457799BBCDFF1, 1'b1, 0, 0, 0);
    vecs[1].exp_first  = 48'hCB3D8B0E17F5;
    vecs[1].exp_last   = 48'h1B02EFFC7072;
    vecs[2] = mk_model(64'h133457799BBCDFF1, 1'b0, 0, 3, 0);
    vecs[3] = mk_model(64'h133457799BBCDFF1, 1'b0, 0, 0, 7);
    vecs[4] = mk_model(64'h0000000000000000, 1'b0, 0, 0, 0);
    vecs[4].exp_first = '0; vecs[4].exp_second = '0; vecs[4].exp_last = '0;
    vecs[4].exp_par   = 1'b1;
    vecs[5] = mk_model(64'h0000000000000000, 1'b1, 0, 0, 0);
    vecs[5].exp_par   = 1'b1;
    vecs[6] = mk_model(64'h133457799BBCDFF1, 1'b0, 0, 0, 0);
    vecs[6].exp_first = 48'h1B02EFFC7072;
    for (int i = 7; i < 11; i++)
      vecs[i] = mk_model({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, 0, 0);

    repeat (3) @(negedge clk);
    check("reset_start_ready", start_ready_p, 1);
    check("reset_valid", subkey_valid_p, 0);
    check("reset_subkey", subkey_p, 0);
    check("reset_round", round_p, 0);
    check("reset_done", done_p, 0);
    check("reset_parity", parity_err_p, 0);
    check("reset_valid_default_inst", subkey_valid_n, 0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_schedule(vecs[i]);
    reset_mid_schedule();
    for (int i = 6; i < 11; i++) run_schedule(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
